// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// CorePack
// Shared types and helpers for the instruction/data memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, REQ, WAIT)
//   arb_owner_e : which requester owns the shared port (INST, DATA)
//   align_dword : clears the byte offset of an address (doubleword aligned)
// ----------------------------------------------------------------------------
package CorePack;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_owner_e;

    // Instruction fetches always read a whole doubleword.
    function automatic logic [ADDR_W-1:0] align_dword(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a data load/store port onto one
// shared memory port with a single outstanding transaction. Data requests
// win over fetches when both are pending in the same idle cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_req_*  / i_resp_*        fetch requester (read-only, doubleword aligned)
//   d_req_*  / d_resp_*        data requester (load or masked store)
//   m_req_*  / m_resp_*        shared memory port
//   busy                       high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import CorePack::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,

    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [MASK_W-1:0] d_req_wmask,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [MASK_W-1:0] m_req_wmask,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_data,

    output logic              busy
);

    arb_state_e        state_r;
    arb_owner_e        owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MASK_W-1:0] wmask_r;

    // FSM and request latch; reset overrides any grant seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= INST;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_req_valid) begin
                        owner_r <= DATA;
                        we_r    <= d_req_we;
                        addr_r  <= d_req_addr;
                        wdata_r <= d_req_wdata;
                        wmask_r <= d_req_wmask;
                        state_r <= REQ;
                    end else if (i_req_valid) begin
                        owner_r <= INST;
                        we_r    <= 1'b0;
                        addr_r  <= align_dword(i_req_addr);
                        wdata_r <= {DATA_W{1'b0}};
                        wmask_r <= {MASK_W{1'b0}};
                        state_r <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (m_req_ready) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    // Return to IDLE only; a new grant waits for the next cycle.
                    if (m_resp_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Grant handshakes: only in IDLE, data first, never while in reset.
    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        if (!rst && (state_r == IDLE)) begin
            if (d_req_valid) begin
                d_req_ready = 1'b1;
            end else if (i_req_valid) begin
                i_req_ready = 1'b1;
            end else begin
                i_req_ready = 1'b0;
            end
        end else begin
            d_req_ready = 1'b0;
        end
    end

    // Shared-port request fields are driven from the latch only in REQ.
    always_comb begin
        m_req_valid = 1'b0;
        m_req_we    = 1'b0;
        m_req_addr  = {ADDR_W{1'b0}};
        m_req_wdata = {DATA_W{1'b0}};
        m_req_wmask = {MASK_W{1'b0}};
        if (state_r == REQ) begin
            m_req_valid = 1'b1;
            m_req_we    = we_r;
            m_req_addr  = addr_r;
            m_req_wdata = wdata_r;
            m_req_wmask = wmask_r;
        end else begin
            m_req_valid = 1'b0;
        end
    end

    // Response steering: a response outside WAIT is stale and dropped.
    always_comb begin
        i_resp_valid = 1'b0;
        i_resp_data  = {DATA_W{1'b0}};
        d_resp_valid = 1'b0;
        d_resp_data  = {DATA_W{1'b0}};
        if (!rst && (state_r == WAIT) && m_resp_valid) begin
            if (owner_r == DATA) begin
                d_resp_valid = 1'b1;
                d_resp_data  = m_resp_data;
            end else begin
                i_resp_valid = 1'b1;
                i_resp_data  = m_resp_data;
            end
        end else begin
            i_resp_valid = 1'b0;
        end
    end

    // Busy flag follows the state register directly.
    always_comb begin
        busy = (state_r != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scenario tasks drive the arbiter and the shared-port side; expected
// responses are queued when the bench issues m_resp_valid and a negedge
// monitor pops them against the i/d response pulses.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic [63:0] data;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [63:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid;
    logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [7:0]  d_req_wmask;
    logic        m_req_valid, m_req_ready, m_req_we, m_resp_valid;
    logic [63:0] m_req_addr, m_req_wdata, m_resp_data;
    logic [7:0]  m_req_wmask;
    logic        busy;

    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t i_q[$];
    exp_t d_q[$];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Response monitor: every cycle, compare i/d response pulses against the scoreboard.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (mon_en) begin
            n_vec++;
            if (i_resp_valid === 1'b1) begin
                if (i_q.size() == 0) begin
                    n_err++; $display("FAIL i_resp_spurious: got pulse data=%h, required no pulse", i_resp_data);
                end else begin
                    e = i_q.pop_front();
                    if (e.chk && (i_resp_data !== e.data)) begin
                        n_err++; $display("FAIL i_resp_data: got %h, required %h", i_resp_data, e.data);
                    end
                end
            end else if (i_q.size() != 0) begin
                e = i_q.pop_front();
                n_err++; $display("FAIL i_resp_missing: got valid=%b, required pulse with %h", i_resp_valid, e.data);
            end else if (i_resp_data !== 64'd0) begin
                n_err++; $display("FAIL i_resp_data_idle: got %h, required %h", i_resp_data, 64'd0);
            end
            n_vec++;
            if (d_resp_valid === 1'b1) begin
                if (d_q.size() == 0) begin
                    n_err++; $display("FAIL d_resp_spurious: got pulse data=%h, required no pulse", d_resp_data);
                end else begin
                    e = d_q.pop_front();
                    if (e.chk && (d_resp_data !== e.data)) begin
                        n_err++; $display("FAIL d_resp_data: got %h, required %h", d_resp_data, e.data);
                    end
                end
            end else if (d_q.size() != 0) begin
                e = d_q.pop_front();
                n_err++; $display("FAIL d_resp_missing: got valid=%b, required pulse with %h", d_resp_valid, e.data);
            end else if (d_resp_data !== 64'd0) begin
                n_err++; $display("FAIL d_resp_data_idle: got %h, required %h", d_resp_data, 64'd0);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 64'h88;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h77;
        d_req_wdata = 64'h1; d_req_wmask = 8'hFF;
        m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_data = JUNK;
        @(negedge clk); #1;
        n_vec++; if (d_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_d_ready: got %b, required %b", d_req_ready, 1'b0); end
        n_vec++; if (i_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_i_ready: got %b, required %b", i_req_ready, 1'b0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required %b", busy, 1'b0); end
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_grant_blocked: got busy=%b, required %b", busy, 1'b0); end
        n_vec++; if (m_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b, required %b", m_req_valid, 1'b0); end
        rst = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        m_req_ready = 1'b0;
        #1;
        n_vec++; if (m_req_addr !== 64'd0) begin n_err++; $display("FAIL rst_m_addr: got %h, required %h", m_req_addr, 64'd0); end
        n_vec++; if (m_req_wmask !== 8'd0) begin n_err++; $display("FAIL rst_m_wmask: got %h, required %h", m_req_wmask, 8'd0); end
        mon_en = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 64'h1004; m_req_ready = 1'b1; #1;
        n_vec++; if (i_req_ready !== 1'b1) begin n_err++; $display("FAIL fetch_i_ready: got %b, required %b", i_req_ready, 1'b1); end
        n_vec++; if (d_req_ready !== 1'b0) begin n_err++; $display("FAIL fetch_d_ready: got %b, required %b", d_req_ready, 1'b0); end
        @(negedge clk);
        i_req_valid = 1'b0; i_req_addr = 64'd0; #1;
        n_vec++; if (m_req_valid !== 1'b1) begin n_err++; $display("FAIL fetch_m_valid: got %b, required %b", m_req_valid, 1'b1); end
        n_vec++; if (m_req_addr !== 64'h1000) begin n_err++; $display("FAIL fetch_m_addr: got %h, required %h", m_req_addr, 64'h1000); end
        n_vec++; if (m_req_we !== 1'b0) begin n_err++; $display("FAIL fetch_m_we: got %b, required %b", m_req_we, 1'b0); end
        n_vec++; if (m_req_wmask !== 8'd0) begin n_err++; $display("FAIL fetch_m_wmask: got %h, required %h", m_req_wmask, 8'd0); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b, required %b", busy, 1'b1); end
        @(negedge clk);
        m_resp_valid = 1'b1; m_resp_data = 64'hAABB; i_q.push_back('{data: 64'hAABB, chk: 1'b1}); #1;
        n_vec++; if (m_req_valid !== 1'b0) begin n_err++; $display("FAIL fetch_wait_m_valid: got %b, required %b", m_req_valid, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; m_req_ready = 1'b0; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle_busy: got %b, required %b", busy, 1'b0); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 64'h3008;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h2000;
        d_req_wdata = 64'h55; d_req_wmask = 8'h0F; m_req_ready = 1'b1; #1;
        n_vec++; if (d_req_ready !== 1'b1) begin n_err++; $display("FAIL prio_d_ready: got %b, required %b", d_req_ready, 1'b1); end
        n_vec++; if (i_req_ready !== 1'b0) begin n_err++; $display("FAIL prio_i_ready: got %b, required %b", i_req_ready, 1'b0); end
        @(negedge clk);
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = 64'd0; d_req_wmask = 8'd0; #1;
        n_vec++; if (m_req_we !== 1'b1) begin n_err++; $display("FAIL prio_m_we: got %b, required %b", m_req_we, 1'b1); end
        n_vec++; if (m_req_addr !== 64'h2000) begin n_err++; $display("FAIL prio_m_addr: got %h, required %h", m_req_addr, 64'h2000); end
        n_vec++; if (m_req_wdata !== 64'h55) begin n_err++; $display("FAIL prio_m_wdata: got %h, required %h", m_req_wdata, 64'h55); end
        n_vec++; if (m_req_wmask !== 8'h0F) begin n_err++; $display("FAIL prio_m_wmask: got %h, required %h", m_req_wmask, 8'h0F); end
        n_vec++; if (i_req_ready !== 1'b0) begin n_err++; $display("FAIL prio_i_ready_req: got %b, required %b", i_req_ready, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b1; m_resp_data = 64'h1111; d_q.push_back('{data: 64'd0, chk: 1'b0}); #1;
        n_vec++; if (i_req_ready !== 1'b0) begin n_err++; $display("FAIL prio_i_ready_resp: got %b, required %b", i_req_ready, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; #1;
        n_vec++; if (i_req_ready !== 1'b1) begin n_err++; $display("FAIL prio_i_ready_t3: got %b, required %b", i_req_ready, 1'b1); end
        @(negedge clk);
        i_req_valid = 1'b0; i_req_addr = 64'd0; #1;
        n_vec++; if (m_req_addr !== 64'h3008) begin n_err++; $display("FAIL prio_i_m_addr: got %h, required %h", m_req_addr, 64'h3008); end
        n_vec++; if (m_req_we !== 1'b0) begin n_err++; $display("FAIL prio_i_m_we: got %b, required %b", m_req_we, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b1; m_resp_data = 64'h1234_5678; i_q.push_back('{data: 64'h1234_5678, chk: 1'b1});
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; m_req_ready = 1'b0;
    endtask

    task automatic test_stall();
        @(negedge clk);
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h4C;
        d_req_wdata = 64'h77; d_req_wmask = 8'h3C; m_req_ready = 1'b0; #1;
        n_vec++; if (d_req_ready !== 1'b1) begin n_err++; $display("FAIL stall_d_ready: got %b, required %b", d_req_ready, 1'b1); end
        @(negedge clk);
        d_req_valid = 1'b0; d_req_addr = 64'd0; d_req_wdata = 64'd0; d_req_wmask = 8'd0;
        i_req_valid = 1'b1; i_req_addr = 64'h9000;
        for (int c = 0; c < 4; c++) begin
            // A response while the request is still pending must be ignored.
            m_resp_valid = (c == 2) ? 1'b1 : 1'b0;
            #1;
            n_vec++; if (m_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_m_valid[%0d]: got %b, required %b", c, m_req_valid, 1'b1); end
            n_vec++; if (m_req_addr !== 64'h4C) begin n_err++; $display("FAIL stall_m_addr[%0d]: got %h, required %h", c, m_req_addr, 64'h4C); end
            n_vec++; if (m_req_wdata !== 64'h77 || m_req_wmask !== 8'h3C || m_req_we !== 1'b0) begin
                n_err++; $display("FAIL stall_m_fields[%0d]: got we=%b wdata=%h wmask=%h, required we=0 wdata=%h wmask=%h", c, m_req_we, m_req_wdata, m_req_wmask, 64'h77, 8'h3C);
            end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy[%0d]: got %b, required %b", c, busy, 1'b1); end
            n_vec++; if (i_req_ready !== 1'b0) begin n_err++; $display("FAIL stall_i_ready[%0d]: got %b, required %b", c, i_req_ready, 1'b0); end
            @(negedge clk);
        end
        m_resp_valid = 1'b0; m_req_ready = 1'b1;
        @(negedge clk);
        m_req_ready = 1'b0;
        m_resp_valid = 1'b1; m_resp_data = 64'hCAFE_F00D; d_q.push_back('{data: 64'hCAFE_F00D, chk: 1'b1});
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; i_req_valid = 1'b0; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_end_busy: got %b, required %b", busy, 1'b0); end
    endtask

    task automatic test_spurious_idle();
        @(negedge clk);
        m_resp_valid = 1'b1; m_resp_data = 64'h5A5A; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_busy0: got %b, required %b", busy, 1'b0); end
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_busy1: got %b, required %b", busy, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; #1;
        n_vec++; if (m_req_valid !== 1'b0) begin n_err++; $display("FAIL spur_m_valid: got %b, required %b", m_req_valid, 1'b0); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 64'h500; m_req_ready = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstw_busy_wait: got %b, required %b", busy, 1'b1); end
        @(negedge clk);
        rst = 1'b0; m_resp_valid = 1'b1; m_resp_data = 64'h9999; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstw_busy: got %b, required %b", busy, 1'b0); end
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK;
        i_req_valid = 1'b1; i_req_addr = 64'h60F; #1;
        n_vec++; if (i_req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_i_ready: got %b, required %b", i_req_ready, 1'b1); end
        @(negedge clk);
        i_req_valid = 1'b0; #1;
        n_vec++; if (m_req_addr !== 64'h608) begin n_err++; $display("FAIL rstw_m_addr: got %h, required %h", m_req_addr, 64'h608); end
        @(negedge clk);
        m_resp_valid = 1'b1; m_resp_data = 64'h4242; i_q.push_back('{data: 64'h4242, chk: 1'b1});
        @(negedge clk);
        m_resp_valid = 1'b0; m_resp_data = JUNK; m_req_ready = 1'b0; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstw_end_busy: got %b, required %b", busy, 1'b0); end
    endtask

    // Watchdog so a stuck bench still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_stall();
        test_spurious_idle();
        test_reset_in_wait();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", i_q.size(), d_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  in  1  clock; all state on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_req_valid  in  1  fetch request; held until i_req_ready.
REQ-004 i_req_ready  out  1  fetch request accepted this cycle.
REQ-005 i_req_addr  in  64  fetch address.
REQ-006 i_resp_valid  out  1  one-cycle pulse, fetch data valid.
REQ-007 i_resp_data  out  64  fetched doubleword.
REQ-008 d_req_valid  in  1  data request; held until d_req_ready.
REQ-009 d_req_we  in  1  1 = store, 0 = load.
REQ-010 d_req_addr  in  64  data address.
REQ-011 d_req_wdata  in  64  store data.
REQ-012 d_req_wmask  in  8  store byte mask.
REQ-013 d_req_ready  out  1  data request accepted this cycle.
REQ-014 d_resp_valid  out  1  one-cycle pulse, load data valid or store acknowledged.
REQ-015 d_resp_data  out  64  load doubleword; don't-care for stores.
REQ-016 m_req_valid  out  1  shared-port request valid.
REQ-017 m_req_ready  in  1  shared port accepts request.
REQ-018 m_req_we  out  1  write enable to shared port.
REQ-019 m_req_addr  out  64  shared-port address.
REQ-020 m_req_wdata  out  64  shared-port write data.
REQ-021 m_req_wmask  out  8  shared-port write mask.
REQ-022 m_resp_valid  in  1  shared-port response (read data or write ack).
REQ-023 m_resp_data  in  64  shared-port read data.
REQ-024 busy  out  1  high whenever state is not IDLE.

Function
REQ-025 FSM states IDLE, REQ, WAIT; owner register INST or DATA.
REQ-026 IDLE: if d_req_valid, assert d_req_ready combinationally, latch we/addr/wdata/wmask, owner=DATA, go REQ; otherwise, if i_req_valid, assert i_req_ready, latch addr with bits [2:0] forced to 0, we=0, wmask=0, owner=INST, go REQ.
REQ-027 DATA has fixed priority over INST when both are valid in the same IDLE cycle; INST is granted on the next IDLE.
REQ-028 At most one requester ready per cycle; both readies are 0 outside IDLE.
REQ-029 REQ: m_req_valid=1 with latched fields, stable until m_req_ready; on m_req_valid & m_req_ready go WAIT.
REQ-030 WAIT: on m_resp_valid, pulse owner's resp_valid in the same cycle, drive resp_data = m_resp_data, go IDLE.
REQ-031 Minimum accept-to-response latency is 2 cycles (ready at T, m_req handshake at T+1, m_resp_valid at T+2).
REQ-032 Exactly one outstanding shared-port transaction; no new grant in the response cycle (next grant earliest T+3).
REQ-033 m_resp_valid in IDLE or REQ is ignored and produces no resp pulse.
REQ-034 Non-owner resp_valid stays 0; resp_data outputs read 0 when their resp_valid is 0.
REQ-035 m_req_valid, m_req_we are 0 and m_req_addr/wdata/wmask are 0 outside REQ.

Reset
REQ-036 rst: state=IDLE, owner=INST, latched fields=0, all valid/ready outputs 0 in the following cycle; an in-flight transaction is abandoned, and its late response is discarded per REQ-033.
REQ-037 rst has priority over every transition, including a grant in the same cycle.

Structure
REQ-038 arb_state_e (IDLE/REQ/WAIT) and arb_owner_e (INST/DATA) are defined in CorePack; no sub-module is used, and the block is a single FSM with a request-latch register.

Verification
REQ-039 i_req_valid=1, addr=0x1004; m_req_ready=1, m_resp_valid at T+2, data=0xAABB -> m_req_addr=0x1000 at T+1; i_resp_valid pulse at T+2, data 0xAABB.
REQ-040 i and d valid at T, d store addr=0x2000, wdata=0x55, wmask=0x0F -> d_req_ready at T, m_req_we=1 at T+1; after d ack, i_req_ready at or after T+3.
REQ-041 m_req_ready held 0 for 4 cycles -> m_req fields constant across those cycles; busy=1; no resp pulses.
REQ-042 Spurious m_resp_valid in IDLE -> no i/d resp pulse; state stays IDLE.
REQ-043 rst asserted in WAIT, response arrives the next cycle -> no resp pulse; busy=0; next request is served normally.
